// File: rtl/mux_pkg.sv
// Shared constants and helpers for the channel funnel and its arbiters.
package mux_pkg;

  localparam logic MODE_STATIC = 1'b0;
  localparam logic MODE_RR     = 1'b1;

  // Constant-foldable ceil(log2(v)) for tools lacking $clog2.
  function automatic int clog2(input int v);
    int r;
    int x;
    r = 0;
    x = v - 1;
    while (x > 0) begin
      r++;
      x = x >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/mux_nx1_rr_rr_pick.sv
// Round-robin pick: first set request at or after ptr, wrapping modulo N.
module rr_pick #(
  parameter int N  = 8,
  parameter int SW = 3
) (
  input  logic [N-1:0]  req,
  input  logic [SW-1:0] ptr,
  output logic          gnt_vld,
  output logic [SW-1:0] gnt_idx
);

  logic [N-1:0]  rot;
  logic [SW-1:0] off;
  logic [SW:0]   sum;

  always_comb begin
    // rot[k] is the request k positions after ptr; modular index keeps non-power-of-two N exact
    for (int k = 0; k < N; k++) begin
      logic [SW:0] j;
      j = (SW+1)'(k) + {1'b0, ptr};
      if (j >= (SW+1)'(N)) j = j - (SW+1)'(N);
      rot[k] = req[j[SW-1:0]];
    end

    gnt_vld = |rot;

    off = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (rot[k]) off = SW'(k);
    end

    sum = {1'b0, off} + {1'b0, ptr};
    if (sum >= (SW+1)'(N)) sum = sum - (SW+1)'(N);
    gnt_idx = sum[SW-1:0];
  end

endmodule

// File: rtl/mux_nx1_rr.sv
// N-channel registered funnel with valid/ready handshakes, static or round-robin select.
module mux_nx1_rr
  import mux_pkg::*;
#(
  parameter  int N  = 8,
  parameter  int W  = 8,
  localparam int SW = (N > 1) ? clog2(N) : 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N*W-1:0] I,
  input  logic [N-1:0]   V,
  output logic [N-1:0]   RDY,
  input  logic [SW-1:0]  S,
  input  logic           MODE,
  output logic [W-1:0]   Y,
  output logic [SW-1:0]  Y_CH,
  output logic           Y_VALID,
  input  logic           Y_READY
);

  logic [SW-1:0] ptr;
  logic [SW-1:0] rr_idx;
  logic          rr_vld;
  logic          st_vld;
  logic [SW-1:0] g;
  logic          gnt_vld;
  logic          free;
  logic          acc;
  logic [W-1:0]  y_nxt;
  logic [SW:0]   ptr_inc;
  logic [SW-1:0] ptr_nxt;

  rr_pick #(.N(N), .SW(SW)) u_pick (
    .req     (V),
    .ptr     (ptr),
    .gnt_vld (rr_vld),
    .gnt_idx (rr_idx)
  );

  always_comb begin
    // Compare against every legal index so S >= N simply finds no match
    st_vld = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (S == SW'(k)) st_vld = V[k];
    end

    g       = (MODE == MODE_RR) ? rr_idx : S;
    gnt_vld = (MODE == MODE_RR) ? rr_vld : st_vld;
    free    = ~Y_VALID | Y_READY;
    acc     = free & gnt_vld & ~rst;

    // AND-OR select: unselected channels contribute nothing, even if X
    RDY   = '0;
    y_nxt = '0;
    for (int k = 0; k < N; k++) begin
      if (g == SW'(k)) y_nxt = I[k*W +: W];
      RDY[k] = acc && (g == SW'(k));
    end

    ptr_inc = {1'b0, g} + (SW+1)'(1);
    ptr_nxt = (ptr_inc == (SW+1)'(N)) ? '0 : ptr_inc[SW-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      Y       <= '0;
      Y_CH    <= '0;
      Y_VALID <= 1'b0;
      ptr     <= '0;
    end else begin
      if (acc) begin
        Y       <= y_nxt;
        Y_CH    <= g;
        Y_VALID <= 1'b1;
        if (MODE == MODE_RR) ptr <= ptr_nxt;
      end else if (Y_READY) begin
        Y_VALID <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mux_nx1_rr.sv
// Directed bench for mux_nx1_rr: an N=8 instance and a non-power-of-two N=6 instance.
module tb_mux_nx1_rr;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic [63:0] I8;
  logic [7:0]  V8, RDY8, Y8;
  logic [2:0]  S8, Y_CH8;
  logic        MODE8, Y_VALID8, Y_READY8;

  logic [47:0] I6;
  logic [5:0]  V6, RDY6;
  logic [7:0]  Y6;
  logic [2:0]  S6, Y_CH6;
  logic        MODE6, Y_VALID6, Y_READY6;

  int checks = 0;
  int errors = 0;

  mux_nx1_rr #(.N(8), .W(8)) dut8 (
    .clk(clk), .rst(rst), .I(I8), .V(V8), .RDY(RDY8), .S(S8), .MODE(MODE8),
    .Y(Y8), .Y_CH(Y_CH8), .Y_VALID(Y_VALID8), .Y_READY(Y_READY8)
  );

  mux_nx1_rr #(.N(6), .W(8)) dut6 (
    .clk(clk), .rst(rst), .I(I6), .V(V6), .RDY(RDY6), .S(S6), .MODE(MODE6),
    .Y(Y6), .Y_CH(Y_CH6), .Y_VALID(Y_VALID6), .Y_READY(Y_READY6)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Entered at posedge+1 with inputs driven; expects channel ch accepted this cycle.
  task automatic xfer8(input int ch);
    logic [7:0] onehot;
    onehot = 8'(1 << ch);
    #1;
    chk("rdy8", 64'(RDY8), 64'(onehot));
    @(posedge clk); #1;
    chk("ych8", 64'(Y_CH8), 64'(ch));
    chk("y8", 64'(Y8), 64'(8'hA0 | 8'(ch)));
    chk("yvld8", 64'(Y_VALID8), 64'd1);
  endtask

  task automatic xfer6(input int ch);
    logic [5:0] onehot;
    onehot = 6'(1 << ch);
    #1;
    chk("rdy6", 64'(RDY6), 64'(onehot));
    @(posedge clk); #1;
    chk("ych6", 64'(Y_CH6), 64'(ch));
    chk("y6", 64'(Y6), 64'(8'hB0 | 8'(ch)));
    chk("yvld6", 64'(Y_VALID6), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    for (int k = 0; k < 8; k++) I8[k*8 +: 8] = 8'hA0 | 8'(k);
    for (int k = 0; k < 6; k++) I6[k*8 +: 8] = 8'hB0 | 8'(k);
    rst = 1'b1;
    V8 = 8'hFF; S8 = 3'd0; MODE8 = 1'b0; Y_READY8 = 1'b1;
    V6 = 6'h00; S6 = 3'd0; MODE6 = 1'b0; Y_READY6 = 1'b0;

    // Reset state
    #2;
    chk("rst_y", 64'(Y8), 64'd0);
    chk("rst_ych", 64'(Y_CH8), 64'd0);
    chk("rst_vld", 64'(Y_VALID8), 64'd0);
    chk("rst_rdy", 64'(RDY8), 64'd0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    // Static select, channel 5
    MODE8 = 1'b0; S8 = 3'd5; V8 = 8'h20; Y_READY8 = 1'b1;
    #1;
    chk("st_rdy", 64'(RDY8), 64'h20);
    @(posedge clk); #1;
    V8 = 8'hFF; Y_READY8 = 1'b0; S8 = 3'd2;
    chk("st_y", 64'(Y8), 64'hA5);
    chk("st_ych", 64'(Y_CH8), 64'd5);
    chk("st_vld", 64'(Y_VALID8), 64'd1);

    // Backpressure: output frozen, nothing accepted
    for (int c = 0; c < 4; c++) begin
      #1;
      chk("bp_rdy", 64'(RDY8), 64'd0);
      @(posedge clk); #1;
      chk("bp_y", 64'(Y8), 64'hA5);
      chk("bp_ych", 64'(Y_CH8), 64'd5);
      chk("bp_vld", 64'(Y_VALID8), 64'd1);
    end
    Y_READY8 = 1'b1;
    xfer8(2);

    // Round-robin full load, pointer untouched by the static transfers
    MODE8 = 1'b1; V8 = 8'hFF;
    for (int i = 0; i < 10; i++) xfer8(i % 8);

    // Asynchronous reset mid-cycle with data held
    Y_READY8 = 1'b0; V8 = 8'h00;
    #1;
    chk("pre_rst_vld", 64'(Y_VALID8), 64'd1);
    #1 rst = 1'b1;
    #1;
    chk("arst_y", 64'(Y8), 64'd0);
    chk("arst_ych", 64'(Y_CH8), 64'd0);
    chk("arst_vld", 64'(Y_VALID8), 64'd0);
    V8 = 8'hFF; Y_READY8 = 1'b1;
    #1;
    chk("arst_rdy", 64'(RDY8), 64'd0);
    #1 rst = 1'b0;

    // Sparse requests with wrap
    V8 = 8'b1001_0001;
    xfer8(0); xfer8(4); xfer8(7); xfer8(0); xfer8(4);

    // Fresh pointer, then drop channel 4 after the first grant
    Y_READY8 = 1'b0;
    #1 rst = 1'b1;
    #1 rst = 1'b0;
    V8 = 8'b1001_0001; Y_READY8 = 1'b1;
    xfer8(0);
    V8 = 8'b1000_0001;
    xfer8(7); xfer8(0); xfer8(7);

    // Static mode leaves the pointer alone; round-robin resumes at 0, not 4
    MODE8 = 1'b0; S8 = 3'd3; V8 = 8'hFF;
    xfer8(3);
    MODE8 = 1'b1;
    xfer8(0);
    V8 = 8'h00;

    // N=6: out-of-range static select never grants
    MODE6 = 1'b0; S6 = 3'd6; V6 = 6'h3F; Y_READY6 = 1'b1;
    for (int c = 0; c < 3; c++) begin
      if (c == 2) S6 = 3'd7;
      #1;
      chk("oor_rdy", 64'(RDY6), 64'd0);
      @(posedge clk); #1;
      chk("oor_vld", 64'(Y_VALID6), 64'd0);
    end

    // N=6 round-robin wraps from 5 back to 0
    MODE6 = 1'b1;
    for (int i = 0; i < 7; i++) xfer6(i % 6);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
